// File: rtl/is_palindrome_pkg.sv
// ============================================================================
// Module      : is_palindrome_pkg
// Description : Shared constants and the mismatch-count width helper for the
//               bit-palindrome detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package is_palindrome_pkg;

  localparam int              DEFAULT_WIDTH = 32;
  localparam int              STATS_W       = 16;
  localparam logic [STATS_W-1:0] STATS_MAX  = 16'hFFFF;

  // Count of mirror-pair mismatches spans 0..width/2 inclusive.
  function automatic int cnt_w(input int width);
    return $clog2(width / 2 + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pair_mismatch_count.sv
// ============================================================================
// Module      : pair_mismatch_count
// Description : Combinational popcount of mismatched mirror bit pairs
//               a[i] ^ a[WIDTH-1-i]; the centre bit of an odd word is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pair_mismatch_count
  import is_palindrome_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  output logic [CNT_W-1:0] mismatch_count
);

  localparam int c_pairs = WIDTH / 2;

  logic [c_pairs-1:0] w_mis;
  logic [CNT_W-1:0]   w_count;

  for (genvar gi = 0; gi < c_pairs; gi++) begin : g_pair
    assign w_mis[gi] = a[gi] ^ a[WIDTH-1-gi];
  end

  always_comb begin
    w_count = '0;
    for (int i = 0; i < c_pairs; i++) begin
      w_count = w_count + CNT_W'(w_mis[i]);
    end
  end

  assign mismatch_count = w_count;

endmodule

`default_nettype wire

// File: rtl/is_palindrome_core.sv
// ============================================================================
// Module      : is_palindrome_core
// Description : Bit-palindrome detector with combinational verdict, registered
//               result/valid/mismatch count. Optional word statistics enabled
//               by defining IS_PALINDROME_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module is_palindrome_core
  import is_palindrome_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   A,
  input  logic               in_valid,
  output logic               O,
  output logic               out_valid,
  output logic               out_pal,
`ifdef IS_PALINDROME_STATS_EN
  input  logic               stats_clr,
  output logic [STATS_W-1:0] chk_cnt,
  output logic [STATS_W-1:0] pal_cnt,
`endif
  output logic [CNT_W-1:0]   out_mismatch
);

  logic [CNT_W-1:0] w_count;
  logic             w_pal;

  pair_mismatch_count #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_pair_mismatch_count (
    .a              (A),
    .mismatch_count (w_count)
  );

  assign w_pal = (w_count == '0);
  assign O     = w_pal;

  logic             r_valid;
  logic             r_pal;
  logic [CNT_W-1:0] r_mismatch;

  // Verdict and count hold when no word is accepted; only the strobe drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_pal      <= 1'b0;
      r_mismatch <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_pal      <= w_pal;
        r_mismatch <= w_count;
      end
    end
  end

  assign out_valid    = r_valid;
  assign out_pal      = r_pal;
  assign out_mismatch = r_mismatch;

`ifdef IS_PALINDROME_STATS_EN
  logic [STATS_W-1:0] r_chk_cnt;
  logic [STATS_W-1:0] r_pal_cnt;

  // Clear has priority over counting; both counters saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk_cnt <= '0;
      r_pal_cnt <= '0;
    end else if (stats_clr) begin
      r_chk_cnt <= '0;
      r_pal_cnt <= '0;
    end else if (in_valid) begin
      if (r_chk_cnt != STATS_MAX) r_chk_cnt <= r_chk_cnt + 1'b1;
      if (w_pal && (r_pal_cnt != STATS_MAX)) r_pal_cnt <= r_pal_cnt + 1'b1;
    end
  end

  assign chk_cnt = r_chk_cnt;
  assign pal_cnt = r_pal_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_is_palindrome_core.sv
// ============================================================================
// Module      : tb_is_palindrome_core
// Description : Directed self-checking bench for is_palindrome_core (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_is_palindrome_core;

  localparam int c_width = 32;
  localparam int c_cnt_w = 5;

  logic               clk;
  logic               rst_n;
  logic [c_width-1:0] A;
  logic               in_valid;
  logic               O;
  logic               out_valid;
  logic               out_pal;
  logic [c_cnt_w-1:0] out_mismatch;
`ifdef IS_PALINDROME_STATS_EN
  logic               stats_clr;
  logic [15:0]        chk_cnt;
  logic [15:0]        pal_cnt;
`endif

  int total;
  int bad;

  logic [c_width-1:0] vec_a   [5];
  logic               vec_pal [5];
  logic [c_cnt_w-1:0] vec_mm  [5];

  is_palindrome_core #(
    .WIDTH (c_width),
    .CNT_W (c_cnt_w)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .A            (A),
    .in_valid     (in_valid),
    .O            (O),
    .out_valid    (out_valid),
    .out_pal      (out_pal),
`ifdef IS_PALINDROME_STATS_EN
    .stats_clr    (stats_clr),
    .chk_cnt      (chk_cnt),
    .pal_cnt      (pal_cnt),
`endif
    .out_mismatch (out_mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++;
    if (out_pal !== 1'b0) begin bad++; $display("FAIL reset_pal got=%b want=0", out_pal); end
    total++;
    if (out_mismatch !== 5'd0) begin bad++; $display("FAIL reset_mm got=%0d want=0", out_mismatch); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single words separated by idle cycles; also checks hold on idle.
  task automatic test_vectors();
    logic [c_width-1:0] a_tab  [3];
    logic               p_tab  [3];
    logic [c_cnt_w-1:0] m_tab  [3];
    a_tab[0] = 32'hFFFFFFFF; p_tab[0] = 1'b1; m_tab[0] = 5'd0;
    a_tab[1] = 32'hFFFFFFFE; p_tab[1] = 1'b0; m_tab[1] = 5'd1;
    a_tab[2] = 32'h00000000; p_tab[2] = 1'b1; m_tab[2] = 5'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      A = a_tab[k];
      in_valid = 1'b1;
      #1;
      total++;
      if (O !== p_tab[k]) begin bad++; $display("FAIL vec%0d_O got=%b want=%b", k, O, p_tab[k]); end
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL vec%0d_valid got=%b want=1", k, out_valid); end
      total++;
      if (out_pal !== p_tab[k]) begin bad++; $display("FAIL vec%0d_pal got=%b want=%b", k, out_pal, p_tab[k]); end
      total++;
      if (out_mismatch !== m_tab[k]) begin bad++; $display("FAIL vec%0d_mm got=%0d want=%0d", k, out_mismatch, m_tab[k]); end
      @(negedge clk);
      in_valid = 1'b0;
      A = 32'h0000FFFF;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL idle%0d_valid got=%b want=0", k, out_valid); end
      total++;
      if (out_mismatch !== m_tab[k]) begin bad++; $display("FAIL idle%0d_hold_mm got=%0d want=%0d", k, out_mismatch, m_tab[k]); end
      total++;
      if (out_pal !== p_tab[k]) begin bad++; $display("FAIL idle%0d_hold_pal got=%b want=%b", k, out_pal, p_tab[k]); end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      A = vec_a[k];
      in_valid = 1'b1;
      #1;
      total++;
      if (O !== vec_pal[k]) begin bad++; $display("FAIL b2b%0d_O got=%b want=%b", k, O, vec_pal[k]); end
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b%0d_valid got=%b want=1", k, out_valid); end
      total++;
      if (out_pal !== vec_pal[k]) begin bad++; $display("FAIL b2b%0d_pal got=%b want=%b", k, out_pal, vec_pal[k]); end
      total++;
      if (out_mismatch !== vec_mm[k]) begin bad++; $display("FAIL b2b%0d_mm got=%0d want=%0d", k, out_mismatch, vec_mm[k]); end
    end
  endtask

  // Stream still active with mm=15 registered; reset must clear at once.
  task automatic test_mid_reset();
    @(negedge clk);
    #2;
    A = 32'hFFFFFFFF;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", out_valid); end
    total++;
    if (out_pal !== 1'b0) begin bad++; $display("FAIL midrst_pal got=%b want=0", out_pal); end
    total++;
    if (out_mismatch !== 5'd0) begin bad++; $display("FAIL midrst_mm got=%0d want=0", out_mismatch); end
    total++;
    if (O !== 1'b1) begin bad++; $display("FAIL midrst_O_live got=%b want=1", O); end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL inrst_valid got=%b want=0", out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    A = 32'hFFFF8000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL postrst_valid got=%b want=1", out_valid); end
    total++;
    if (out_mismatch !== 5'd15) begin bad++; $display("FAIL postrst_mm got=%0d want=15", out_mismatch); end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

`ifdef IS_PALINDROME_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    stats_clr = 1'b0;
    #1;
    total++;
    if (chk_cnt !== 16'd0 || pal_cnt !== 16'd0) begin bad++; $display("FAIL stats_rst got=%0d/%0d want=0/0", chk_cnt, pal_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      A = vec_a[k];
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (chk_cnt !== 16'd5) begin bad++; $display("FAIL stats_chk got=%0d want=5", chk_cnt); end
    total++;
    if (pal_cnt !== 16'd3) begin bad++; $display("FAIL stats_pal got=%0d want=3", pal_cnt); end
    A = 32'hFFFFFFFF;
    in_valid = 1'b1;
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    total++;
    if (chk_cnt !== 16'd0 || pal_cnt !== 16'd0) begin bad++; $display("FAIL stats_clr got=%0d/%0d want=0/0", chk_cnt, pal_cnt); end
    repeat (70000) @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (chk_cnt !== 16'hFFFF) begin bad++; $display("FAIL stats_sat_chk got=%h want=ffff", chk_cnt); end
    total++;
    if (pal_cnt !== 16'hFFFF) begin bad++; $display("FAIL stats_sat_pal got=%h want=ffff", pal_cnt); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    A = '0;
`ifdef IS_PALINDROME_STATS_EN
    stats_clr = 1'b0;
`endif
    vec_a[0] = 32'hFFFFFFFF; vec_pal[0] = 1'b1; vec_mm[0] = 5'd0;
    vec_a[1] = 32'hFFFFFFFE; vec_pal[1] = 1'b0; vec_mm[1] = 5'd1;
    vec_a[2] = 32'h80000001; vec_pal[2] = 1'b1; vec_mm[2] = 5'd0;
    vec_a[3] = 32'b11010010011000011000011001001011; vec_pal[3] = 1'b1; vec_mm[3] = 5'd0;
    vec_a[4] = 32'hFFFF8000; vec_pal[4] = 1'b0; vec_mm[4] = 5'd15;

    test_reset();
    test_vectors();
    test_back_to_back();
    test_mid_reset();
`ifdef IS_PALINDROME_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/is_palindrome_core.md
# is_palindrome_core

Bit-level palindrome detector for a WIDTH-bit word. It gives an immediate combinational verdict, plus a registered result with valid strobe and a count of mismatched mirror bit pairs. It sits in the number-analysis datapath beside the other number-property checkers and feeds the classification FSM.

## Interface
Parameters:
- WIDTH, 32, word width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH/2+1), width of the mismatch count (5 for WIDTH=32).

Ports:
- clk  input  1  single system clock; all state on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- A  input  WIDTH  word under test.
- in_valid  input  1  A is sampled into the result register this cycle.
- O  output  1  combinational verdict: 1 when A is a bit palindrome.
- out_valid  output  1  registered result valid strobe.
- out_pal  output  1  registered verdict for the sampled word.
- out_mismatch  output  CNT_W  registered number of mismatched mirror pairs.
- stats_clr  input  1  synchronous statistics clear; present only with IS_PALINDROME_STATS_EN.
- chk_cnt  output  16  words checked; present only with IS_PALINDROME_STATS_EN.
- pal_cnt  output  16  palindromes seen; present only with IS_PALINDROME_STATS_EN.

## Operation
- Mirror pair i means bits A[i] and A[WIDTH-1-i], for i = 0..WIDTH/2-1. For odd WIDTH the centre bit is ignored.
- Mismatch vector: m[i] = A[i] XOR A[WIDTH-1-i].
- mismatch count = popcount(m), range 0..WIDTH/2.
- O = (mismatch count == 0), which equals A == bit-reverse(A). O is purely combinational and does not depend on clk, rst_n or in_valid.
- When in_valid=1 on a clock edge:
  - out_valid is set to 1.
  - out_pal is loaded with O.
  - out_mismatch is loaded with the count.
- When in_valid=0 on a clock edge, out_valid is cleared. out_pal and out_mismatch hold their last values.
- No backpressure: every valid word is accepted.

## Timing
- O: zero-cycle latency, settles within the same cycle as A.
- Registered outputs: 1-cycle latency. A sampled at edge N appears at outputs after edge N, with out_valid high for exactly one cycle per accepted word. Back-to-back valids produce back-to-back results.
- Reset (rst_n=0, asynchronous assert):
  - out_valid=0, out_pal=0, out_mismatch=0.
  - With stats enabled: chk_cnt=0, pal_cnt=0.
- Reset deasserts synchronously to clk.
- Reset asserted mid-stream discards any pending result. The first valid after release produces a result one cycle later.
- O remains live during reset.

## Configuration
- IS_PALINDROME_STATS_EN defined:
  - Adds stats_clr, chk_cnt and pal_cnt.
  - On each accepted word, chk_cnt increments by 1; pal_cnt also increments by 1 if O=1.
  - Both counters saturate at 16'hFFFF.
  - If stats_clr and in_valid are high in the same cycle, stats_clr wins and both counters become 0.
- IS_PALINDROME_STATS_EN undefined: those ports and counters do not exist. Remaining behaviour is identical.

## Structure
- Shared package is_palindrome_pkg holds:
  - default WIDTH (32);
  - stats counter width (16) and saturation constant;
  - a CNT_W helper function.
- One sub-module, pair_mismatch_count: combinational WIDTH-bit in, CNT_W-bit mirror-pair mismatch popcount out.
- The top level is_palindrome_core instantiates pair_mismatch_count and holds the result register and the optional stats.

## Test plan
- A=32'hFFFFFFFF, in_valid=1 -> O=1 immediately; next cycle out_valid=1, out_pal=1, out_mismatch=0.
- A=32'hFFFFFFFE -> O=0; next cycle out_pal=0, out_mismatch=1. Then A=32'h00000000 -> O=1, out_mismatch=0.
- A=32'h80000001 -> O=1, out_mismatch=0.
- A=32'b11010010011000011000011001001011 -> O=1, out_mismatch=0.
- A=32'hFFFF8000 -> O=0, out_mismatch=15.
- The five preceding words back-to-back with in_valid=1, then assert rst_n=0 mid-stream -> out_valid=0, out_pal=0 and out_mismatch=0 immediately.
  - With IS_PALINDROME_STATS_EN and no reset, the same sequence -> chk_cnt=5, pal_cnt=3.
  - stats_clr together with in_valid -> both counters 0.
  - 70000 valid words -> both counters hold at 16'hFFFF.
